// File: rtl/fifo_ctrl_pkg.sv
// Shared FIFO sizing: pointer width and data width defaults, plus the derived depth.
// The storage array, the controller and the queue wrapper all take their sizes from here.
package fifo_ctrl_pkg;

  localparam int DEF_MAIN_QUEUE_SIZE = 3;
  localparam int DEF_DATA_SIZE       = 8;

  function automatic int depth_of(input int ptr_w);
    return 2 ** ptr_w;
  endfunction

  localparam int DEF_DEPTH = depth_of(DEF_MAIN_QUEUE_SIZE);

endpackage

// File: rtl/fifo_ctrl.sv
// Pointer/occupancy controller for one FIFO queue. Storage is written synchronously and read
// combinationally, so both strobes and both pointers are valid in the same cycle as the request.
module fifo_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int MAIN_QUEUE_SIZE = DEF_MAIN_QUEUE_SIZE
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [MAIN_QUEUE_SIZE:0]   af_th,
  input  logic [MAIN_QUEUE_SIZE:0]   ae_th,
  output logic                       write,
  output logic                       read,
  output logic [MAIN_QUEUE_SIZE-1:0] ptr_write,
  output logic [MAIN_QUEUE_SIZE-1:0] ptr_read,
  output logic [MAIN_QUEUE_SIZE:0]   count,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int                     DEPTH    = depth_of(MAIN_QUEUE_SIZE);
  localparam logic [MAIN_QUEUE_SIZE:0] FULL_CNT = (MAIN_QUEUE_SIZE+1)'(DEPTH);

  logic acc_push, acc_pop;

  assign full         = (count == FULL_CNT);
  assign empty        = (count == '0);
  assign almost_full  = (count >= af_th);
  assign almost_empty = (count <= ae_th);

  // A full queue can still take a push when the same cycle frees a slot; the read
  // returns the old entry before the write lands on that slot at the edge.
  assign acc_pop  = pop & ~empty;
  assign acc_push = push & (~full | acc_pop);

  assign write = acc_push & ~reset;
  assign read  = acc_pop & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_write <= '0;
      ptr_read  <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (acc_push) ptr_write <= ptr_write + 1'b1;
      if (acc_pop)  ptr_read  <= ptr_read + 1'b1;
      case ({acc_push, acc_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push & full & ~acc_pop) overflow  <= 1'b1;
      if (pop & empty)            underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed bench for fifo_ctrl with a behavioural storage array hung off the strobes/pointers.
module tb_fifo_ctrl;
  import fifo_ctrl_pkg::*;

  localparam int W = DEF_MAIN_QUEUE_SIZE;

  logic         clk = 1'b0;
  logic         reset, push, pop;
  logic [W:0]   af_th, ae_th;
  logic         write, read;
  logic [W-1:0] ptr_write, ptr_read;
  logic [W:0]   count;
  logic         full, empty, almost_full, almost_empty, overflow, underflow;

  logic [DEF_DATA_SIZE-1:0] din;
  logic [DEF_DATA_SIZE-1:0] mem [DEF_DEPTH];
  logic [DEF_DATA_SIZE-1:0] rdata;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fifo_ctrl #(.MAIN_QUEUE_SIZE(W)) dut (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .af_th(af_th), .ae_th(ae_th),
    .write(write), .read(read), .ptr_write(ptr_write), .ptr_read(ptr_read), .count(count),
    .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .overflow(overflow), .underflow(underflow)
  );

  always @(posedge clk) if (write) mem[ptr_write] <= din;
  assign rdata = mem[ptr_read];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic p, input logic q, input logic [DEF_DATA_SIZE-1:0] d);
    push = p; pop = q; din = d;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag, input logic af_exp);
    chk({tag, ".ptr_write"}, ptr_write, 0);
    chk({tag, ".ptr_read"},  ptr_read, 0);
    chk({tag, ".count"},     count, 0);
    chk({tag, ".empty"},     empty, 1);
    chk({tag, ".full"},      full, 0);
    chk({tag, ".ae"},        almost_empty, 1);
    chk({tag, ".af"},        almost_full, af_exp);
    chk({tag, ".ovf"},       overflow, 0);
    chk({tag, ".unf"},       underflow, 0);
  endtask

  initial begin
    logic [7:0] ae_tab, af_tab;

    // Reset with requests active: strobes must stay low; af_th = 0 makes almost_full 1.
    reset = 1'b1; af_th = '0; ae_th = '0;
    drive(1, 1, 8'h00);
    tick(); tick();
    chk("rst.write", write, 0);
    chk("rst.read", read, 0);
    chk_reset("rst", 1'b1);

    // Fill: 8 consecutive pushes.
    reset = 1'b0; af_th = 4'd8; ae_th = '0;
    for (int i = 0; i < 8; i++) begin
      drive(1, 0, 8'(i + 1));
      chk("fill.write", write, 1);
      chk("fill.ptr_write", ptr_write, i);
      tick();
    end
    chk("fill.count", count, 8);
    chk("fill.full", full, 1);
    chk("fill.ptr_write_wrap", ptr_write, 0);
    chk("fill.ovf", overflow, 0);

    // Push into a full queue.
    drive(1, 0, 8'hEE);
    chk("ovf.write", write, 0);
    tick();
    chk("ovf.flag", overflow, 1);
    chk("ovf.count", count, 8);
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 8'h00);
      tick();
      chk("ovf.sticky", overflow, 1);
    end

    // Drain: data 1..8 in order.
    for (int i = 0; i < 8; i++) begin
      drive(0, 1, 8'h00);
      chk("drain.read", read, 1);
      chk("drain.ptr_read", ptr_read, i);
      chk("drain.data", rdata, i + 1);
      tick();
    end
    chk("drain.empty", empty, 1);
    chk("drain.ptr_read_wrap", ptr_read, 0);
    drive(0, 1, 8'h00);
    chk("unf.read", read, 0);
    tick();
    chk("unf.flag", underflow, 1);
    chk("unf.ovf_still", overflow, 1);

    // Simultaneous push/pop on full, then on empty.
    reset = 1'b1; drive(0, 0, 8'h00); tick(); reset = 1'b0;
    chk_reset("rst2", 1'b0);
    for (int i = 0; i < 8; i++) begin drive(1, 0, 8'(11 + i)); tick(); end
    drive(1, 1, 8'd99);
    chk("pp_full.write", write, 1);
    chk("pp_full.read", read, 1);
    chk("pp_full.same_ptr", ptr_read, 0);
    chk("pp_full.ptr_write", ptr_write, 0);
    chk("pp_full.old_data", rdata, 11);
    tick();
    chk("pp_full.count", count, 8);
    chk("pp_full.pw", ptr_write, 1);
    chk("pp_full.pr", ptr_read, 1);
    chk("pp_full.ovf", overflow, 0);
    for (int i = 0; i < 8; i++) begin
      drive(0, 1, 8'h00);
      chk("pp_drain.data", rdata, (i < 7) ? 12 + i : 99);
      tick();
    end
    chk("pp_drain.empty", empty, 1);
    drive(1, 1, 8'd42);
    chk("pp_empty.write", write, 1);
    chk("pp_empty.read", read, 0);
    tick();
    chk("pp_empty.count", count, 1);
    chk("pp_empty.unf", underflow, 1);
    chk("pp_empty.pr", ptr_read, 1);

    // Almost thresholds: ae for counts 0..2, af from 6 up.
    reset = 1'b1; drive(0, 0, 8'h00); tick(); reset = 1'b0;
    af_th = 4'd6; ae_th = 4'd2;
    ae_tab = 8'b0000_0111;
    af_tab = 8'b1100_0000;
    for (int c = 0; c < 8; c++) begin
      drive(1, 0, 8'h00);
      chk("thr.count", count, c);
      chk("thr.ae", almost_empty, ae_tab[c]);
      chk("thr.af", almost_full, af_tab[c]);
      tick();
    end

    // Mixed traffic, reset at count 5, then resume with pointer wrap.
    reset = 1'b1; drive(0, 0, 8'h00); tick(); reset = 1'b0;
    af_th = 4'd8; ae_th = '0;
    begin
      logic [1:0] pat [9];
      pat = '{2'b10, 2'b10, 2'b11, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11, 2'b10};
      for (int i = 0; i < 9; i++) begin
        drive(pat[i][1], pat[i][0], 8'(i));
        tick();
      end
    end
    chk("mid.count", count, 5);
    reset = 1'b1;
    drive(1, 1, 8'h00);
    chk("mid_rst.write", write, 0);
    chk("mid_rst.read", read, 0);
    tick();
    reset = 1'b0;
    chk_reset("mid_rst", 1'b0);
    for (int i = 0; i < 6; i++) begin drive(1, 0, 8'(21 + i)); tick(); end
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 8'(27 + i));
      chk("wrap.pp_data", rdata, 21 + i);
      tick();
    end
    chk("wrap.pw", ptr_write, 2);
    chk("wrap.pr", ptr_read, 4);
    chk("wrap.count", count, 6);
    for (int i = 0; i < 6; i++) begin
      drive(0, 1, 8'h00);
      chk("wrap.data", rdata, 25 + i);
      tick();
    end
    chk("wrap.empty", empty, 1);
    chk("wrap.pr_end", ptr_read, 2);
    chk("wrap.unf", underflow, 0);
    chk("wrap.ovf", overflow, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
